dma_sync_fifo: RTL
==================

Name: dma_sync_fifo

Overview:
Parametrised single-clock FIFO; next generation of the DMA channel data buffer.
- Generalises width and depth.
- Adds occupancy count, programmable almost-full/almost-empty levels, sticky overflow/underflow error flags, synchronous flush, and a read-valid strobe.
- Sits between the DMA read engine (producer) and write engine (consumer) in each channel.

Parameters:
DATA_WIDTH, 32, width of each data word in bits
DEPTH, 16, number of entries; power of two, at least 4
AF_LEVEL, DEPTH-2, almost_full asserts when fill_count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when fill_count <= AE_LEVEL

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush; highest priority
wen  in  1  write request
data_in  in  DATA_WIDTH  write data
ren  in  1  read request
data_out  out  DATA_WIDTH  read data
rd_valid  out  1  data_out holds a freshly read word
fifo_full  out  1  fill_count == DEPTH
fifo_empty  out  1  fill_count == 0
almost_full  out  1  fill_count >= AF_LEVEL
almost_empty  out  1  fill_count <= AE_LEVEL
fill_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous, any time, including mid-burst):
  - Pointers and fill_count go to 0; data_out 0; rd_valid 0.
  - fifo_empty 1, fifo_full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0.
  - Memory contents are don't-care.
- Pointers are $clog2(DEPTH)+1 bits; the low bits address memory and wrap DEPTH-1 -> 0 with no bubble.
- Write accepted iff wen && !fifo_full: mem[wr_ptr] <= data_in, wr_ptr increments.
- Read accepted iff ren && !fifo_empty: rd_ptr increments.
- Flags use pre-edge state: a write is judged against fifo_full, a read against fifo_empty, both as they stood before the edge.
  - When full, a simultaneous wen and ren accepts only the read.
  - When empty, a simultaneous wen and ren accepts only the write.
- fill_count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted. Never exceeds DEPTH and never goes below 0.
- All flags decode combinationally from the fill_count register, so they change on the same edge as fill_count.
- Rejected write: data dropped, memory and pointers unchanged, overflow <= 1. overflow is sticky until clr or reset.
- Rejected read: pointers unchanged, data_out holds its value, rd_valid 0, underflow <= 1. underflow is sticky until clr or reset.
- Read latency: a read accepted at edge N drives data_out = head word and rd_valid = 1 after edge N.
  - rd_valid lasts one cycle per accepted read.
  - data_out holds its value until the next accepted read.
- clr = 1 at an edge:
  - Pointers, fill_count, overflow and underflow go to 0; rd_valid goes to 0; data_out holds.
  - wen and ren in that cycle are ignored and do not set any error flag.
- Write-then-read on an empty FIFO: a word written at edge N can be read by a ren sampled at edge N+1, giving data_out after edge N+1.

Optional Feature:
Macro DMA_FIFO_FWFT_EN enables first-word-fall-through mode.
- Defined:
  - data_out continuously shows mem[rd_ptr]; rd_valid = !fifo_empty.
  - An accepted ren pops the current word, and the next word appears after that edge.
  - A word written to an empty FIFO at edge N is visible on data_out after edge N.
- Not defined: registered read as described in Behaviour.
- fill_count, flags, error flags and clr behave identically in both modes.

Test Plan:
Defaults used throughout: DATA_WIDTH=32, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.
1. Reset: hold rst_n low 2 cycles, then release -> fill_count 0, fifo_empty 1, almost_empty 1, fifo_full 0, data_out 0x00000000, overflow 0, underflow 0.
2. Fill: write 0x00000001..0x00000010 on 16 consecutive cycles.
   -> almost_empty drops after the 3rd write; almost_full rises after the 14th; fifo_full after the 16th; fill_count 16.
   -> A 17th write of 0xDEADBEEF sets overflow 1, leaves fill_count at 16, and 0xDEADBEEF is never read back.
3. Drain: 16 back-to-back reads -> data_out 0x00000001..0x00000010 in order, each with rd_valid one cycle after its ren, then fifo_empty 1.
   -> A 17th read sets underflow 1, rd_valid stays 0, data_out holds 0x00000010.
4. Wrap and simultaneous access: preload 8 words, then 40 cycles of wen=ren=1 with an incrementing pattern.
   -> fill_count stays 8 throughout, pointers wrap at least twice, and read order matches write order.
5. Flush: at fill_count 5, with overflow already set, pulse clr together with wen=1 and data 0xA5A5A5A5.
   -> fill_count 0, fifo_empty 1, overflow 0; 0xA5A5A5A5 is never read back.
6. Mid-burst reset: assert rst_n low asynchronously (between clock edges) during a fill at fill_count 9.
   -> Outputs return to the reset values immediately, without waiting for an edge; normal writes resume after release.
   -> Also run scenarios 2-3 with DMA_FIFO_FWFT_EN defined: data_out = 0x00000001 immediately after the first write edge.

Source files
------------

// File: rtl/dma_sync_fifo.sv
// DMA channel data buffer: single-clock FIFO with occupancy, watermark and sticky error flags.
// Define DMA_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module dma_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         wen,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         ren,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         rd_valid,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH):0]       fill_count,
  output logic                         overflow,
  output logic                         underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_L = CW'(DEPTH);
  localparam logic [CW-1:0] AF_L   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L   = CW'(AE_LEVEL);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dma_sync_fifo: DEPTH must be a power of two and at least 4");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, rd_acc;

  // Acceptance is judged on pre-edge occupancy; clr masks both sides.
  assign wr_acc = wen && !fifo_full  && !clr;
  assign rd_acc = ren && !fifo_empty && !clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (wen && fifo_full)  ovf_d = 1'b1;
      if (ren && fifo_empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

  assign fill_count   = cnt_q;
  assign fifo_full    = (cnt_q == FULL_L);
  assign fifo_empty   = (cnt_q == '0);
  assign almost_full  = (cnt_q >= AF_L);
  assign almost_empty = (cnt_q <= AE_L);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

`ifdef DMA_FIFO_FWFT_EN
  // Head word is exposed directly; masked to zero while nothing is stored.
  assign data_out = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign rd_valid = !fifo_empty;
`else
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rvld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      rvld_q <= 1'b0;
    end else begin
      rvld_q <= rd_acc;
      if (rd_acc) dout_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  assign data_out = dout_q;
  assign rd_valid = rvld_q;
`endif

endmodule
